// File: rtl/ssd_pkg.sv
// ============================================================================
// Module   : ssd_pkg
// Brief    : Glyph codes, segment table, FSM state type and helper functions
//            shared by the seven-segment scan driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd_pkg;

  localparam logic [3:0] DIG_0       = 4'd0;
  localparam logic [3:0] DIG_1       = 4'd1;
  localparam logic [3:0] DIG_2       = 4'd2;
  localparam logic [3:0] DIG_3       = 4'd3;
  localparam logic [3:0] DIG_4       = 4'd4;
  localparam logic [3:0] DIG_5       = 4'd5;
  localparam logic [3:0] DIG_6       = 4'd6;
  localparam logic [3:0] DIG_7       = 4'd7;
  localparam logic [3:0] DIG_8       = 4'd8;
  localparam logic [3:0] DIG_9       = 4'd9;
  localparam logic [3:0] GLYPH_BLANK = 4'hA;
  localparam logic [3:0] GLYPH_MINUS = 4'hB;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  // Active-low segments, bit6=a ... bit0=g; unknown codes go dark.
  function automatic logic [6:0] glyph_to_seg(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      DIG_0:       seg = 7'b0000001;
      DIG_1:       seg = 7'b1001111;
      DIG_2:       seg = 7'b0010010;
      DIG_3:       seg = 7'b0000110;
      DIG_4:       seg = 7'b1001100;
      DIG_5:       seg = 7'b0100100;
      DIG_6:       seg = 7'b0100000;
      DIG_7:       seg = 7'b0001111;
      DIG_8:       seg = 7'b0000000;
      DIG_9:       seg = 7'b0000100;
      GLYPH_MINUS: seg = 7'b1111110;
      default:     seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssd_bin2bcd_seq.sv
// ============================================================================
// Module   : ssd_bin2bcd_seq
// Brief    : Iterative double-dabble converter, one bit per clock, DATA_W
//            clocks per conversion, with overflow detection into NIB nibbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_bin2bcd_seq
  import ssd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NIB    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bin_in,
  output logic              busy,
  output logic              done,
  output logic [4*NIB-1:0]  bcd,
  output logic              ovf
);

  localparam int c_sr_w  = 4 * NIB + DATA_W;
  localparam int c_cnt_w = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);
  localparam int unsigned c_max = pow10(NIB) - 1;

  state_t              r_state, w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
  logic [c_sr_w-1:0]   r_sr, w_sr_nxt, w_adj;
  logic                r_ovf, w_ovf_nxt;
  logic                w_range_ovf;

  assign w_range_ovf = {{(32-DATA_W){1'b0}}, bin_in} > c_max;

  always_comb begin
    w_adj = r_sr;
    for (int n = 0; n < NIB; n++) begin
      if (r_sr[DATA_W+4*n +: 4] >= 4'd5)
        w_adj[DATA_W+4*n +: 4] = r_sr[DATA_W+4*n +: 4] + 4'd3;
    end
  end

  // The final shift and the result hand-off share one edge: done and bcd
  // present the post-shift value so the caller commits on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sr_nxt    = r_sr;
    w_ovf_nxt   = r_ovf;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CONV;
          w_cnt_nxt   = '0;
          w_sr_nxt    = {{(4*NIB){1'b0}}, bin_in};
          w_ovf_nxt   = w_range_ovf;
        end
      end
      CONV: begin
        w_sr_nxt  = {w_adj[c_sr_w-2:0], 1'b0};
        w_ovf_nxt = r_ovf | w_adj[c_sr_w-1];
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
          done        = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sr    <= w_sr_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign busy = (r_state == CONV);
  assign bcd  = w_sr_nxt[c_sr_w-1 -: 4*NIB];
  assign ovf  = w_ovf_nxt;

endmodule

`default_nettype wire

// File: rtl/ssd_scan_driver.sv
// ============================================================================
// Module   : ssd_scan_driver
// Brief    : Multiplexed common-anode seven-segment driver with sequential
//            BCD conversion, sign glyph and overflow indication.
//            Optional build macro SSD_LEADING_ZERO_BLANK_EN blanks leading
//            zero magnitude digits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DATA_W       = 8,
  parameter int SIGNED       = 1,
  parameter int REFRESH_BITS = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg
);

  localparam int c_mag   = (SIGNED != 0) ? DIGITS - 1 : DIGITS;
  localparam int c_idx_w = $clog2(DIGITS);

  logic                    w_busy, w_done, w_ovf, w_accept, w_neg;
  logic [DATA_W-1:0]       w_mag;
  logic [4*c_mag-1:0]      w_bcd;
  logic                    r_cap_neg;
  logic [4*c_mag-1:0]      r_disp_bcd;
  logic                    r_disp_neg, r_disp_ovf;
  logic [REFRESH_BITS-1:0] r_presc;
  logic [c_idx_w-1:0]      r_idx;
  logic [DIGITS-1:0]       r_anode, w_anode_nxt;
  logic [6:0]              r_seg;
  logic [3:0]              w_cur;
  logic [3:0]              w_code [DIGITS];
  logic [c_mag-1:0]        w_lead;

  assign w_accept = load && !w_busy;
  assign w_neg    = (SIGNED != 0) && value[DATA_W-1];
  assign w_mag    = w_neg ? (~value + 1'b1) : value;

  ssd_bin2bcd_seq #(
    .DATA_W (DATA_W),
    .NIB    (c_mag)
  ) u_bcd (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_accept),
    .bin_in (w_mag),
    .busy   (w_busy),
    .done   (w_done),
    .bcd    (w_bcd),
    .ovf    (w_ovf)
  );

  // Display registers only move on the commit edge, so CONV never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_neg  <= 1'b0;
      r_disp_bcd <= '0;
      r_disp_neg <= 1'b0;
      r_disp_ovf <= 1'b0;
    end else begin
      if (w_accept) r_cap_neg <= w_neg;
      if (w_done) begin
        r_disp_bcd <= w_bcd;
        r_disp_neg <= r_cap_neg;
        r_disp_ovf <= w_ovf;
      end
    end
  end

`ifdef SSD_LEADING_ZERO_BLANK_EN
  logic w_run;
  always_comb begin
    w_run  = 1'b1;
    w_lead = '0;
    for (int k = 0; k < c_mag; k++) begin
      w_run = w_run && (r_disp_bcd[4*(c_mag-1-k) +: 4] == 4'd0);
      if (k < c_mag - 1) w_lead[k] = w_run;
    end
  end
`else
  assign w_lead = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if ((SIGNED != 0) && (i == 0)) begin : g_sign
      assign w_code[i] = (r_disp_neg && !r_disp_ovf) ? GLYPH_MINUS : GLYPH_BLANK;
    end else begin : g_mag
      // k = magnitude digit position, 0 = most significant
      localparam int K = (SIGNED != 0) ? i - 1 : i;
      assign w_code[i] = r_disp_ovf ? GLYPH_MINUS :
                         w_lead[K]  ? GLYPH_BLANK :
                                      r_disp_bcd[4*(c_mag-1-K) +: 4];
    end
  end

  always_comb begin
    w_cur       = GLYPH_BLANK;
    w_anode_nxt = '1;
    for (int j = 0; j < DIGITS; j++) begin
      if (r_idx == c_idx_w'(j)) w_cur = w_code[j];
      w_anode_nxt[DIGITS-1-j] = (r_idx != c_idx_w'(j));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_anode <= '1;
      r_seg   <= 7'b1111111;
    end else begin
      r_presc <= r_presc + 1'b1;
      if (&r_presc)
        r_idx <= (r_idx == c_idx_w'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_anode <= w_anode_nxt;
      r_seg   <= glyph_to_seg(w_cur);
    end
  end

  assign busy     = w_busy;
  assign overflow = r_disp_ovf;
  assign anode    = r_anode;
  assign seg      = r_seg;

endmodule

`default_nettype wire

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Parametrised multiplexed seven-segment driver, next generation of the team's fixed 4-digit signed display block. It accepts a DATA_W-bit value through a load/busy handshake. It converts the value to BCD sequentially using iterative double-dabble, so no combinational divider is needed. It then time-multiplexes DIGITS common-anode digits, with a sign glyph and overflow indication. It sits between datapath result registers and the board's anode and segment pins.

Parameters:
DIGITS, 4, number of physical digits (2..8); digit 0 is leftmost.
DATA_W, 8, input value width (4..16).
SIGNED, 1, 1 means two's-complement input with the leftmost digit reserved for sign; 0 means unsigned with all digits used for magnitude.
REFRESH_BITS, 18, each digit is active for 2^REFRESH_BITS clk cycles.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
load  in  1  single-cycle request to capture value; honoured only when busy=0.
value  in  DATA_W  number to display.
busy  out  1  high while a conversion is in progress.
overflow  out  1  high while the displayed value did not fit in the magnitude digits.
anode  out  DIGITS  active-low digit enables; bit DIGITS-1 is digit 0 (leftmost).
seg  out  7  active-low segments, bit6=a ... bit0=g.

Behaviour:
- One clock domain. Reset is asynchronous and active-low.
- Reset values:
  - outputs: anode all 1, seg 7'b1111111, busy 0, overflow 0.
  - internal: FSM IDLE, display value 0, scan index 0, prescaler 0.
- Magnitude digit count: MAG = DIGITS-1 if SIGNED, else DIGITS.
- Capture (load=1 and IDLE):
  - If SIGNED and value[DATA_W-1]=1: neg=1, magnitude = (~value)+1, taken as DATA_W-bit unsigned. The most negative value gives 2^(DATA_W-1).
  - Otherwise neg=0 and magnitude = value.
- FSM states:
  - IDLE: load accepted -> CONV.
  - CONV: runs exactly DATA_W cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts the BCD:binary register left by 1. A shift count register counts 0..DATA_W-1.
  - Leaving CONV: commit BCD digits, neg and ovf to the display registers in one edge, then return to IDLE.
- Timing and handshake:
  - busy=1 for exactly DATA_W cycles, starting the cycle after the load edge.
  - New glyphs appear no earlier than the commit edge. The old display is held unchanged during CONV, so there is no tearing.
  - load while busy=1 is ignored; no queueing.
  - load asserted on the same cycle busy falls is ignored. It is accepted on the next cycle.
- Overflow:
  - ovf=1 if any '1' is shifted out of nibble MAG-1 during CONV, or if the final value exceeds 10^MAG-1.
  - When committed ovf=1: every magnitude digit shows minus/dash (seg 7'b1111110), the sign digit shows blank, and overflow=1.
- Glyphs (code -> seg):
  - 0..9 use the team's standard table, e.g. 0=0000001, 1=1001111, 2=0010010, 7=0001111, 8=0000000.
  - BLANK=1111111, MINUS=1111110.
  - Unused codes display BLANK.
- Sign digit: MINUS if neg=1, else BLANK.
- Scan:
  - The prescaler counts 0..2^REFRESH_BITS-1. At terminal count the index advances and wraps from DIGITS-1 to 0; non-power-of-2 DIGITS must wrap correctly.
  - anode and seg are registered: they update one cycle after an index change and always change on the same edge.
  - Exactly one anode bit is low at any time after the first post-reset cycle.
- Reset mid-CONV: conversion is abandoned and the display returns to value 0.

Optional Feature:
Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined: magnitude digits to the left of the most significant non-zero digit show BLANK. The rightmost magnitude digit always shows its digit, even for 0. The sign stays in the fixed leftmost position.
- Undefined: all magnitude digits are shown, including leading zeros.
- Overflow display is identical in both builds.

Decomposition:
- Package ssd_pkg holds:
  - glyph code constants (DIG_0..DIG_9, GLYPH_BLANK=4'hA, GLYPH_MINUS=4'hB);
  - the glyph-to-segment function;
  - FSM state typedef {IDLE, CONV}.
- One sub-module, ssd_bin2bcd_seq, implements the iterative double-dabble engine with start/busy/done handshake and the ovf flag.
- The top module handles capture, display registers, blanking, scan and output registers.

Test Plan:
All scenarios use DIGITS=4, DATA_W=8, SIGNED=1, REFRESH_BITS=2 unless stated; build without the macro unless stated.
1. Reset: rst_n low -> anode=1111, seg=1111111, busy=0. After release, scan shows BLANK,0,0,0, and anode cycles 0111,1011,1101,1110 every 4 cycles.
2. load value=8'h7F -> busy high exactly 8 cycles, then digits BLANK,1,2,7 (1111111,1001111,0010010,0001111), overflow=0.
3. load 8'h80 -> -,1,2,8. load 8'hFF -> -,0,0,1; with SSD_LEADING_ZERO_BLANK_EN, load 8'hFF -> -,BLANK,BLANK,1.
4. load 8'h05 followed by a second load 8'h09 three cycles later -> the second load is ignored and the display becomes BLANK,0,0,5 with no intermediate glyphs.
5. DIGITS=3, value 8'd100 -> digits BLANK,MINUS,MINUS and overflow=1. Then load 8'd99 -> BLANK,9,9 and overflow=0.
6. Pull rst_n low 4 cycles into CONV -> busy=0 immediately, display returns to value 0, and the next load completes normally.
